// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: request/response, trap/mret and CSR-file port bundle for csr_access_ctrl
// Ports (all signals, grouped):
//    rdy_in                     global ready from the pipeline
//    req_* / resp_*             Zicsr instruction request and old-value response handshakes
//    trap_* / mret_*            trap entry and MRET requests with one-cycle acks
//    redirect_*                 one-cycle PC redirect pulse and target
//    csr_w1_*/csr_w2_*          CSR file write ports
//    csr_r1_*/csr_r2_*          CSR file read ports (combinational read data)
// slave is the controller's view, master is the view of the surrounding pipeline + CSR file.
interface csr_access_ctrl_if #(
   parameter int XLEN       = 32,
   parameter int CSR_ADDR_W = 12
);
   logic                  rdy_in;
   logic                  req_valid, req_ready;
   logic [2:0]            req_funct3;
   logic [CSR_ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]       req_src;
   logic [4:0]            req_rs1, req_rd;
   logic                  resp_valid, resp_ready, resp_illegal;
   logic [4:0]            resp_rd;
   logic [XLEN-1:0]       resp_data;
   logic                  trap_valid, trap_ack;
   logic [XLEN-1:0]       trap_cause, trap_pc, trap_tval;
   logic                  mret_valid, mret_ack;
   logic                  redirect_valid;
   logic [XLEN-1:0]       redirect_pc;
   logic                  csr_w1_en, csr_w2_en, csr_r1_en, csr_r2_en;
   logic [CSR_ADDR_W-1:0] csr_w1_addr, csr_w2_addr, csr_r1_addr, csr_r2_addr;
   logic [XLEN-1:0]       csr_w1_data, csr_w2_data, csr_r1_data, csr_r2_data;
   modport slave (
      input  rdy_in, req_valid, req_funct3, req_addr, req_src, req_rs1, req_rd, resp_ready,
             trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, csr_r1_data, csr_r2_data,
      output req_ready, resp_valid, resp_rd, resp_data, resp_illegal, trap_ack, mret_ack,
             redirect_valid, redirect_pc, csr_w1_en, csr_w1_addr, csr_w1_data,
             csr_w2_en, csr_w2_addr, csr_w2_data, csr_r1_en, csr_r1_addr, csr_r2_en, csr_r2_addr
   );
   modport master (
      output rdy_in, req_valid, req_funct3, req_addr, req_src, req_rs1, req_rd, resp_ready,
             trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, csr_r1_data, csr_r2_data,
      input  req_ready, resp_valid, resp_rd, resp_data, resp_illegal, trap_ack, mret_ack,
             redirect_valid, redirect_pc, csr_w1_en, csr_w1_addr, csr_w1_data,
             csr_w2_en, csr_w2_addr, csr_w2_data, csr_r1_en, csr_r1_addr, csr_r2_en, csr_r2_addr
   );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences Zicsr ops, trap entry and MRET as read-then-write cycles on the M-mode CSR file
// Ports:
//    clk_in    clock
//    rst_n_in  asynchronous active-low reset
//    bus       csr_access_ctrl_if.slave (request/response, trap/mret, redirect, CSR file ports)
module csr_access_ctrl #(
   parameter int XLEN       = 32,
   parameter int CSR_ADDR_W = 12
) (
   input logic               clk_in,
   input logic               rst_n_in,
   csr_access_ctrl_if.slave  bus
);
   typedef enum logic [3:0] {
      IDLE, CSR_RD, CSR_WR, CSR_HOLD, TRAP_RD, TRAP_WR0, TRAP_WR1, MRET_RD, MRET_WR, REDIR
   } state_t;
   localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(12'h300);
   localparam logic [CSR_ADDR_W-1:0] A_MTVEC   = CSR_ADDR_W'(12'h305);
   localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(12'h341);
   localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(12'h342);
   localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(12'h343);
   // mstatus fields touched on trap/mret: MPP[12:11], MPIE[7], MIE[3]
   localparam logic [XLEN-1:0] M_CLR = XLEN'(32'h1888);
   localparam logic [XLEN-1:0] M_MPP = XLEN'(32'h1800);
   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [CSR_ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       src_q, src_d, old_q, old_d, cause_q, cause_d, pc_q, pc_d, tval_q, tval_d;
   logic [XLEN-1:2]       tvec_q, tvec_d;
   logic [4:0]            rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic                  go, idle, legal, resp_st;
   logic [XLEN-1:0]       new_val, trap_mstatus, mret_mstatus;

   function automatic logic is_legal(input logic [CSR_ADDR_W-1:0] a);
      return (a >= CSR_ADDR_W'(12'h300) && a <= CSR_ADDR_W'(12'h306)) ||
             (a >= CSR_ADDR_W'(12'h340) && a <= CSR_ADDR_W'(12'h344));
   endfunction

   assign go      = rst_n_in && bus.rdy_in;
   assign idle    = state_q == IDLE;
   assign legal   = is_legal(addr_q);
   assign resp_st = state_q == CSR_WR || state_q == CSR_HOLD;
   assign new_val = op_q == 2'b01 ? src_q : op_q == 2'b10 ? (old_q | src_q) : (old_q & ~src_q);
   assign trap_mstatus = (old_q & ~M_CLR) | M_MPP | (XLEN'(old_q[3]) << 7);
   assign mret_mstatus = (old_q & ~M_CLR) | M_MPP | XLEN'(32'h80) | (XLEN'(old_q[7]) << 3);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         src_q   <= '0;
         old_q   <= '0;
         cause_q <= '0;
         pc_q    <= '0;
         tval_q  <= '0;
         tvec_q  <= '0;
         rd_q    <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         src_q   <= src_d;
         old_q   <= old_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         tval_q  <= tval_d;
         tvec_q  <= tvec_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.rdy_in)
         case (state_q)
            IDLE:             state_d = bus.trap_valid ? TRAP_RD : bus.mret_valid ? MRET_RD :
                                        !bus.req_valid ? IDLE : is_legal(bus.req_addr) ? CSR_RD : CSR_WR;
            CSR_RD:           state_d = CSR_WR;
            CSR_WR, CSR_HOLD: state_d = bus.resp_ready ? IDLE : CSR_HOLD;
            TRAP_RD:          state_d = TRAP_WR0;
            TRAP_WR0:         state_d = TRAP_WR1;
            TRAP_WR1:         state_d = REDIR;
            MRET_RD:          state_d = MRET_WR;
            MRET_WR:          state_d = REDIR;
            default:          state_d = IDLE;
         endcase
   end

   // Request/trap fields are captured on acceptance; read data is captured only in read states
   always_comb begin
      op_d    = op_q;
      addr_d  = addr_q;
      src_d   = src_q;
      old_d   = old_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      tval_d  = tval_q;
      tvec_d  = tvec_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (bus.rdy_in && idle && bus.trap_valid) begin
         cause_d = bus.trap_cause;
         pc_d    = bus.trap_pc;
         tval_d  = bus.trap_tval;
      end else if (bus.rdy_in && idle && !bus.mret_valid && bus.req_valid) begin
         op_d   = bus.req_funct3[1:0];
         addr_d = bus.req_addr;
         // immediate forms carry only a 5-bit zimm
         src_d  = bus.req_funct3[2] ? XLEN'(bus.req_src[4:0]) : bus.req_src;
         rd_d   = bus.req_rd;
         // set/clear with rs1/zimm of zero must not write
         wr_d   = !(bus.req_funct3[1] && bus.req_rs1 == 5'd0);
      end
      if (bus.rdy_in && state_q == CSR_RD) old_d = bus.csr_r1_data;
      if (bus.rdy_in && (state_q == TRAP_RD || state_q == MRET_RD)) begin
         tvec_d = bus.csr_r1_data[XLEN-1:2];
         old_d  = bus.csr_r2_data;
      end
   end

   always_comb begin
      bus.req_ready      = go && idle && !bus.trap_valid && !bus.mret_valid;
      bus.trap_ack       = go && idle && bus.trap_valid;
      bus.mret_ack       = go && idle && !bus.trap_valid && bus.mret_valid;
      bus.resp_valid     = go && resp_st;
      bus.resp_rd        = resp_st ? rd_q : 5'd0;
      bus.resp_illegal   = resp_st && !legal;
      bus.resp_data      = (resp_st && legal) ? old_q : '0;
      bus.redirect_valid = go && state_q == REDIR;
      bus.redirect_pc    = state_q == REDIR ? {tvec_q, 2'b00} : '0;
      bus.csr_r1_en      = go && (state_q == CSR_RD || state_q == TRAP_RD || state_q == MRET_RD);
      bus.csr_r1_addr    = state_q == CSR_RD ? addr_q : state_q == TRAP_RD ? A_MTVEC :
                           state_q == MRET_RD ? A_MEPC : '0;
      bus.csr_r2_en      = go && (state_q == TRAP_RD || state_q == MRET_RD);
      bus.csr_r2_addr    = (state_q == TRAP_RD || state_q == MRET_RD) ? A_MSTATUS : '0;
      bus.csr_w1_en      = go && ((state_q == CSR_WR && legal && wr_q) || state_q == TRAP_WR0 ||
                                  state_q == TRAP_WR1);
      bus.csr_w1_addr    = state_q == CSR_WR ? addr_q : state_q == TRAP_WR0 ? A_MEPC :
                           state_q == TRAP_WR1 ? A_MTVAL : '0;
      bus.csr_w1_data    = state_q == CSR_WR ? new_val : state_q == TRAP_WR0 ? pc_q :
                           state_q == TRAP_WR1 ? tval_q : '0;
      bus.csr_w2_en      = go && (state_q == TRAP_WR0 || state_q == TRAP_WR1 || state_q == MRET_WR);
      bus.csr_w2_addr    = state_q == TRAP_WR0 ? A_MCAUSE :
                           (state_q == TRAP_WR1 || state_q == MRET_WR) ? A_MSTATUS : '0;
      bus.csr_w2_data    = state_q == TRAP_WR0 ? cause_q : state_q == TRAP_WR1 ? trap_mstatus :
                           state_q == MRET_WR ? mret_mstatus : '0;
   end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: scoreboard bench for csr_access_ctrl with a behavioural CSR file
module tb_csr_access_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   csr_access_ctrl_if #(.XLEN(32), .CSR_ADDR_W(12)) bus ();
   csr_access_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

   localparam int K_W1 = 0, K_W2 = 1, K_RESP = 2, K_REDIR = 3;

   typedef struct {
      int          kind;
      logic [11:0] addr;
      logic [31:0] data;
      logic        ill;
   } ev_t;

   ev_t exp_q[$];
   int tests = 0, fails = 0, redir_cnt = 0, r0, lat;

   logic [31:0] mem [0:4095];
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [31:0] pl_data = '0;
   logic        any_out;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (bus.csr_w1_en) mem[bus.csr_w1_addr] <= bus.csr_w1_data;
      if (bus.csr_w2_en) mem[bus.csr_w2_addr] <= bus.csr_w2_data;
   end
   assign bus.csr_r1_data = mem[bus.csr_r1_addr];
   assign bus.csr_r2_data = mem[bus.csr_r2_addr];

   assign any_out = |{bus.req_ready, bus.resp_valid, bus.resp_rd, bus.resp_data, bus.resp_illegal,
                      bus.trap_ack, bus.mret_ack, bus.redirect_valid, bus.redirect_pc,
                      bus.csr_w1_en, bus.csr_w1_addr, bus.csr_w1_data,
                      bus.csr_w2_en, bus.csr_w2_addr, bus.csr_w2_data,
                      bus.csr_r1_en, bus.csr_r1_addr, bus.csr_r2_en, bus.csr_r2_addr};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push(input int kind, input logic [11:0] addr, input logic [31:0] data, input logic ill);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.ill  = ill;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [11:0] addr, input logic [31:0] data, input logic ill);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d addr %0h data %0h ill %0b, expected none",
                  kind, addr, data, ill);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event_kind%0d", kind), {4'(kind), addr, data, ill},
               {4'(e.kind), e.addr, e.data, e.ill});
      end
   endtask

   // Monitor: every write, response handshake and redirect must match the next expected event
   always @(negedge clk) begin
      if (bus.csr_w1_en) observe(K_W1, bus.csr_w1_addr, bus.csr_w1_data, 1'b0);
      if (bus.csr_w2_en) observe(K_W2, bus.csr_w2_addr, bus.csr_w2_data, 1'b0);
      if (bus.resp_valid && bus.resp_ready) observe(K_RESP, {7'd0, bus.resp_rd}, bus.resp_data, bus.resp_illegal);
      if (bus.redirect_valid) begin
         redir_cnt++;
         observe(K_REDIR, 12'h0, bus.redirect_pc, 1'b0);
      end
   end

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                         input logic [4:0] rs1, input logic [4:0] rd);
      bit ok = 0;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_addr = a;
      bus.req_src = s; bus.req_rs1 = rs1; bus.req_rd = rd;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.req_ready;
      end
      check("req_accept", ok, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          input bit rst_mid);
      bit ok = 0;
      @(posedge clk); #1;
      bus.trap_valid = 1'b1; bus.trap_cause = cause; bus.trap_pc = pc; bus.trap_tval = tval;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.trap_ack;
      end
      check("trap_ack", ok, 1);
      @(posedge clk); #1;
      bus.trap_valid = 1'b0;
      if (rst_mid) begin
         @(posedge clk); #1;
         rst_n = 1'b0;
      end
   endtask

   task automatic do_mret();
      bit ok = 0;
      @(posedge clk); #1;
      bus.mret_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.mret_ack;
      end
      check("mret_ack", ok, 1);
      @(posedge clk); #1;
      bus.mret_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.rdy_in = 1'b1; bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
      bus.req_src = '0; bus.req_rs1 = '0; bus.req_rd = '0; bus.resp_ready = 1'b1;
      bus.trap_valid = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
      bus.mret_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", any_out, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", bus.req_ready, 1);

      poke(12'h340, 32'h0);
      push(K_W1, 12'h340, 32'hDEADBEEF, 0);
      push(K_RESP, 12'd5, 32'h0, 0);
      do_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5);
      wait_done("csrrw");

      poke(12'h340, 32'h0F0F);
      push(K_W1, 12'h340, 32'h0F00, 0);
      push(K_RESP, 12'd6, 32'h0F0F, 0);
      do_req(3'b011, 12'h340, 32'h00FF, 5'd2, 5'd6);
      wait_done("csrrc");
      push(K_RESP, 12'd6, 32'h0F00, 0);
      do_req(3'b010, 12'h340, 32'h00FF, 5'd0, 5'd6);
      wait_done("csrrs_rs1_zero");
      check("csrrs_rs1_zero_mem", mem[12'h340], 32'h0F00);

      poke(12'h305, 32'h80000103);
      poke(12'h300, 32'h8);
      push(K_W1, 12'h341, 32'h1000, 0);
      push(K_W2, 12'h342, 32'h2, 0);
      push(K_W1, 12'h343, 32'h13, 0);
      push(K_W2, 12'h300, 32'h1880, 0);
      push(K_REDIR, 12'h0, 32'h80000100, 0);
      do_trap(32'h2, 32'h1000, 32'h13, 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.redirect_valid && lat < 20);
      check("trap_latency", lat, 4);
      wait_done("trap");

      poke(12'h341, 32'h1004);
      push(K_W2, 12'h300, 32'h1888, 0);
      push(K_REDIR, 12'h0, 32'h1004, 0);
      do_mret();
      wait_done("mret");

      push(K_W1, 12'h341, 32'h2000, 0);
      push(K_W2, 12'h342, 32'h7, 0);
      push(K_W1, 12'h343, 32'h0, 0);
      push(K_W2, 12'h300, 32'h1880, 0);
      push(K_REDIR, 12'h0, 32'h80000100, 0);
      push(K_W1, 12'h340, 32'h0FF0, 0);
      push(K_RESP, 12'd9, 32'h0F00, 0);
      r0 = redir_cnt;
      fork
         do_trap(32'h7, 32'h2000, 32'h0, 0);
         begin
            do_req(3'b010, 12'h340, 32'h00F0, 5'd3, 5'd9);
            check("req_after_redirect", redir_cnt > r0, 1);
         end
      join
      wait_done("trap_vs_req");

      bus.resp_ready = 1'b0;
      push(K_W1, 12'h305, 32'h80000200, 0);
      push(K_RESP, 12'd7, 32'h80000103, 0);
      do_req(3'b001, 12'h305, 32'h80000200, 5'd1, 5'd7);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.resp_valid && lat < 20);
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         check("resp_hold", {bus.resp_valid, bus.resp_rd, bus.resp_data}, {1'b1, 5'd7, 32'h80000103});
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      wait_done("resp_backpressure");
      check("resp_backpressure_mem", mem[12'h305], 32'h80000200);

      poke(12'h344, 32'h55);
      push(K_RESP, 12'd3, 32'h55, 0);
      do_req(3'b010, 12'h344, 32'h0, 5'd0, 5'd3);
      wait_done("addr_344");
      poke(12'h306, 32'h66);
      push(K_W1, 12'h306, 32'h67, 0);
      push(K_RESP, 12'd2, 32'h66, 0);
      do_req(3'b010, 12'h306, 32'h1, 5'd1, 5'd2);
      wait_done("addr_306");
      push(K_RESP, 12'd4, 32'h0, 1);
      do_req(3'b001, 12'h307, 32'h1, 5'd1, 5'd4);
      wait_done("addr_307");
      push(K_RESP, 12'd4, 32'h0, 1);
      do_req(3'b011, 12'h33F, 32'h1, 5'd1, 5'd4);
      wait_done("addr_33f");
      push(K_RESP, 12'd4, 32'h0, 1);
      do_req(3'b001, 12'h7C0, 32'h1, 5'd1, 5'd4);
      wait_done("addr_7c0");

      push(K_W1, 12'h340, 32'h1F, 0);
      push(K_RESP, 12'd0, 32'h0FF0, 0);
      do_req(3'b101, 12'h340, 32'h1F, 5'h1F, 5'd0);
      wait_done("csrrwi_rd0");
      push(K_RESP, 12'd0, 32'h1F, 0);
      do_req(3'b111, 12'h340, 32'h0, 5'd0, 5'd0);
      wait_done("csrrci_zero");

      push(K_W1, 12'h340, 32'hA5, 0);
      push(K_RESP, 12'd1, 32'h1F, 0);
      do_req(3'b001, 12'h340, 32'hA5, 5'd1, 5'd1);
      bus.rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("freeze_idle_ports", {bus.csr_r1_en, bus.csr_w1_en, bus.resp_valid}, 3'b000);
      end
      @(posedge clk); #1;
      bus.rdy_in = 1'b1;
      wait_done("freeze");

      poke(12'h343, 32'h77);
      do_trap(32'h9, 32'h3000, 32'h44, 1);
      @(negedge clk);
      check("mid_reset_outputs", any_out, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_reset_req_ready", bus.req_ready, 1);
      check("mid_reset_mtval", mem[12'h343], 32'h77);
      check("mid_reset_mepc", mem[12'h341], 32'h2000);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
